// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot/auto-reload modes, underflow pulse and sticky irq.
// Optional prescaler is built when DOWN_TIMER_PRESCALER_EN is defined.
module down_timer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PSC_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_val_i,
    input  logic                 mode_i,
    input  logic                 en_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic                 irq_clr_i,
    output logic [WIDTH-1:0]     q_o,
    output logic                 busy_o,
    output logic                 underflow_o,
    output logic                 irq_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             underflow_q, underflow_d;
    logic             irq_q, irq_d;
    logic             tick;
    logic             expire;

`ifdef DOWN_TIMER_PRESCALER_EN
    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;

    // Exact compare: lowering psc_i below the count lets it wrap before the next tick.
    always_comb begin
        tick      = (state_q == RUN) && en_i && (psc_cnt_q == psc_i);
        psc_cnt_d = psc_cnt_q;
        if (clear_i || load_i) begin
            psc_cnt_d = '0;
        end else if (state_q == RUN && en_i) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end
`else
    logic unused_psc;
    assign unused_psc = ^psc_i;
    assign tick       = (state_q == RUN) && en_i;
`endif

    // clear_i beats load_i beats tick; a load or clear swallows a coincident expiry.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire   = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_i) begin
            state_d  = RUN;
            count_d  = load_val_i;
            reload_d = load_val_i;
            mode_d   = mode_i;
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                expire = 1'b1;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    state_d = DONE;
                end
            end
        end
        underflow_d = expire;
        irq_d       = expire ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            underflow_q <= underflow_d;
            irq_q       <= irq_d;
        end
    end

    assign q_o         = count_q;
    assign busy_o      = (state_q == RUN);
    assign underflow_o = underflow_q;
    assign irq_o       = irq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus randomized traffic, all checked cycle by cycle
// against a behavioural model of the timer rules.
module tb_down_timer;

    localparam int WIDTH     = 16;
    localparam int PSC_WIDTH = 3;
    localparam int PSC_MOD   = 1 << PSC_WIDTH;

    logic                 clk      = 1'b0;
    logic                 rst_ni   = 1'b0;
    logic                 clear    = 1'b0;
    logic                 load     = 1'b0;
    logic [WIDTH-1:0]     load_val = '0;
    logic                 mode     = 1'b0;
    logic                 en       = 1'b0;
    logic [PSC_WIDTH-1:0] psc      = '0;
    logic                 irq_clr  = 1'b0;
    logic [WIDTH-1:0]     q_o;
    logic                 busy_o;
    logic                 underflow_o;
    logic                 irq_o;
    logic [1:0]           dbg_state;

    down_timer #(
        .WIDTH    (WIDTH),
        .PSC_WIDTH(PSC_WIDTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .clear_i    (clear),
        .load_i     (load),
        .load_val_i (load_val),
        .mode_i     (mode),
        .en_i       (en),
        .psc_i      (psc),
        .irq_clr_i  (irq_clr),
        .q_o        (q_o),
        .busy_o     (busy_o),
        .underflow_o(underflow_o),
        .irq_o      (irq_o),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit psc_built;

    // Model: remaining count, running flag, reload/mode, enabled cycles since last tick.
    int m_q, m_reload, m_pcnt;
    bit m_run, m_auto, m_uf, m_irq;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_reload = 0; m_pcnt = 0;
        m_run = 0; m_auto = 0; m_uf = 0; m_irq = 0;
    endtask

    task automatic model_step();
        bit tick, expire;
        tick   = m_run && en && (!psc_built || m_pcnt == int'(psc));
        expire = tick && (m_q == 0) && !clear && !load;
        m_uf   = expire;
        if (expire) m_irq = 1;
        else if (irq_clr) m_irq = 0;
        if (clear) begin
            m_run = 0; m_q = 0; m_pcnt = 0;
        end else if (load) begin
            m_q = int'(load_val); m_reload = int'(load_val); m_auto = mode;
            m_pcnt = 0; m_run = 1;
        end else if (m_run && en) begin
            m_pcnt = tick ? 0 : (m_pcnt + 1) % PSC_MOD;
            if (tick) begin
                if (m_q > 0) m_q = m_q - 1;
                else if (m_auto) m_q = m_reload;
                else m_run = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("q", 32'(q_o), 32'(m_q));
        check("busy", 32'(busy_o), 32'(m_run));
        check("underflow", 32'(underflow_o), 32'(m_uf));
        check("irq", 32'(irq_o), 32'(m_irq));
    endtask

    task automatic do_load(input int val, input bit md);
        load = 1; load_val = WIDTH'(val); mode = md;
        step();
        load = 0;
    endtask

    // Counts edges after the load until underflow_o is seen; -1 if the bound expires.
    task automatic edges_to_uf(output int edges);
        edges = -1;
        for (int i = 1; i <= 500; i++) begin
            step();
            if (underflow_o) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int edges, pulses, last, per;
`ifdef DOWN_TIMER_PRESCALER_EN
        psc_built = 1;
`else
        psc_built = 0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_q", 32'(q_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_uf", 32'(underflow_o), 0);
        check("rst_irq", 32'(irq_o), 0);
        rst_ni = 1;
        en = 1;
        psc = 0;

        // One-shot, load 3
        exp_q = '{16'd3, 16'd2, 16'd1, 16'd0};
        do_load(3, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check("os_seq", 32'(q_o), 32'(exp_q.pop_front()));
        end
        step();
        check("os_uf", 32'(underflow_o), 1);
        check("os_irq", 32'(irq_o), 1);
        check("os_busy", 32'(busy_o), 0);
        step();
        check("os_uf_single", 32'(underflow_o), 0);
        check("os_q_hold", 32'(q_o), 0);

        // Pause for 4 cycles at q=3
        do_load(5, 0);
        step(); step();
        check("pause_q3", 32'(q_o), 3);
        en = 0;
        repeat (4) begin
            step();
            check("pause_hold", 32'(q_o), 3);
        end
        en = 1;
        edges_to_uf(edges);
        check("pause_expiry_edge", edges + 6, 10);

        // Load coinciding with an expiry tick
        do_load(0, 0);
        load = 1; load_val = 7;
        step();
        load = 0;
        check("ld_exp_uf", 32'(underflow_o), 0);
        check("ld_exp_q", 32'(q_o), 7);
        clear = 1; load = 1; load_val = 9;
        step();
        clear = 0; load = 0;
        check("clr_ld_q", 32'(q_o), 0);
        check("clr_ld_busy", 32'(busy_o), 0);
        do_load(0, 0);
        irq_clr = 1;
        step();
        check("irqclr_exp_uf", 32'(underflow_o), 1);
        check("irqclr_exp_irq", 32'(irq_o), 1);
        step();
        irq_clr = 0;
        check("irqclr_alone", 32'(irq_o), 0);

        // Auto-reload, load 2, psc 1
        psc = 1;
        per = 3 * (psc_built ? 2 : 1);
        do_load(2, 1);
        pulses = 0; last = 0;
        for (int i = 1; i <= 200 && pulses < 4; i++) begin
            irq_clr = (pulses == 2 && i == last + 1);
            step();
            if (irq_clr) check("arl_irq_cleared", 32'(irq_o), 0);
            irq_clr = 0;
            if (underflow_o) begin
                pulses++;
                check("arl_gap", i - last, per);
                check("arl_reload_q", 32'(q_o), 2);
                if (pulses == 3) check("arl_irq_reset", 32'(irq_o), 1);
                last = i;
            end
        end
        check("arl_pulses", pulses, 4);

        // Asynchronous reset mid-count
        psc = 0;
        do_load(100, 0);
        repeat (50) step();
        check("rst_mid_q50", 32'(q_o), 50);
        #2 rst_ni = 0;
        #1;
        check("arst_q", 32'(q_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_uf", 32'(underflow_o), 0);
        check("arst_irq", 32'(irq_o), 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1;
        repeat (5) step();

        // psc 5 one-shot load 3: prescaled only when the prescaler is built
        psc = 5;
        do_load(3, 0);
        edges_to_uf(edges);
        check("psc5_expiry_edge", edges, 4 * (psc_built ? 6 : 1));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            clear    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 6);
            load_val = WIDTH'($urandom_range(0, 12));
            mode     = $urandom_range(0, 1);
            en       = ($urandom_range(0, 99) < 85);
            irq_clr  = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 5)
                psc = PSC_WIDTH'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 7 : 2));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer: the countdown counterpart to the free-running up counter. It counts a loaded value down to zero and reports expiry with a one-cycle underflow pulse and a sticky interrupt. It supports one-shot and auto-reload modes and an optional prescaler. It sits in the utils library and is instantiated by peripheral timers, watchdogs and bus-timeout logic.

## Interface
- `WIDTH`, 32, counter width in bits (≥2)
- `PSC_WIDTH`, 8, prescaler width in bits (≥1)
---
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `clear_i` in 1: synchronous abort; returns to IDLE with count 0
- `load_i` in 1: start/restart the countdown from `load_val_i`
- `load_val_i` in WIDTH: start value; also the reload value
- `mode_i` in 1: 0 = one-shot, 1 = auto-reload; sampled only on `load_i`
- `en_i` in 1: count enable; low pauses the count, prescaler and state
- `psc_i` in PSC_WIDTH: prescale divisor minus one; a tick occurs every `psc_i`+1 enabled cycles
- `irq_clr_i` in 1: clears `irq_o`
- `q_o` out WIDTH: current count
- `busy_o` out 1: high in RUN
- `underflow_o` out 1: one-cycle expiry pulse
- `irq_o` out 1: sticky expiry flag

## Operation
- States are IDLE, RUN and DONE. All outputs reset to 0 and the state resets to IDLE; the reload and mode registers also reset to 0.
- Priority each cycle: `clear_i` > `load_i` > tick.
- `clear_i`:
  - next state IDLE; `q_o`=0; prescaler=0.
  - `underflow_o` is not generated. `irq_o` is unchanged.
- `load_i` in any state:
  - `q_o`←`load_val_i`; reload←`load_val_i`; mode←`mode_i`; prescaler←0; next state RUN.
  - An in-progress expiry in the same cycle is discarded, so no pulse occurs.
- Tick is asserted in RUN when `en_i`=1 and prescaler==`psc_i`; the prescaler then returns to 0. Otherwise, if RUN and `en_i`=1, the prescaler increments. The prescaler holds when `en_i`=0.
- Tick in RUN:
  - `q_o`≠0: `q_o`←`q_o`−1.
  - `q_o`=0: expiry. In auto-reload, `q_o`←reload and the state stays RUN. In one-shot, `q_o` stays 0 and the next state is DONE.
- DONE: `busy_o`=0 and `q_o`=0. It holds until `load_i` or `clear_i`. `en_i` has no effect in IDLE or DONE.
- Expiry sets `irq_o`. `irq_clr_i` clears it. If set and clear occur in the same cycle, set wins.
- `psc_i` changes take effect at the next prescaler compare. If `psc_i` is lowered below the current prescaler value, the prescaler counts up and wraps modulo 2^PSC_WIDTH before the next tick.
- `load_val_i`=0 is legal: expiry happens on the first tick. In auto-reload this gives an expiry every tick.
- The count never wraps below 0.

## Timing
- `load_i` sampled at edge N: `q_o`=`load_val_i` and `busy_o`=1 from N+1.
- Period with `en_i` held high = (`load_val_i`+1)×(`psc_i`+1) cycles, from the load edge to the expiry edge.
- `underflow_o` and the `irq_o` set are registered. They are visible in the cycle after the expiry tick, simultaneously with `q_o` showing the reload value (auto-reload) or 0 with `busy_o`=0 (one-shot).
- `underflow_o` is never high for more than 1 cycle, except in auto-reload with reload=0 and `psc_i`=0, where it stays high continuously.
- A reset assertion mid-count forces all state to 0/IDLE immediately and asynchronously. No pulse is generated.

## Configuration
- `DOWN_TIMER_PRESCALER_EN` defined: the prescaler is built as described.
- `DOWN_TIMER_PRESCALER_EN` undefined:
  - The prescaler register is not instantiated and `psc_i` is ignored.
  - Tick = RUN && `en_i`, so the period is `load_val_i`+1 cycles.
- All other behaviour is identical in both builds.

## Test plan
- One-shot, load 3, psc 0, en 1 → `q_o` 3,2,1,0 on cycles 1-4. `underflow_o` and `irq_o` rise on cycle 5, `busy_o`=0 from cycle 5, and `q_o` stays 0.
- Auto-reload, load 2, psc 1 → `underflow_o` pulses every 6 cycles, 4 pulses observed, and `q_o` returns to 2 with each pulse. `irq_clr_i` clears `irq_o` and the next expiry sets it again.
- Pause: load 5, psc 0, drop `en_i` for 4 cycles when `q_o`=3 → `q_o` holds 3. Expiry is delayed by exactly 4 cycles, at cycle 10.
- Simultaneous events:
  - `load_i`(7) together with an expiry tick → no `underflow_o` pulse, and `q_o`=7 next cycle.
  - `clear_i` with `load_i` → IDLE and `q_o`=0.
  - `irq_clr_i` with expiry → `irq_o` stays 1.
- Reset mid-count (load 100, assert `rst_ni` low at `q_o`=50) → all outputs 0 immediately. After release, the block stays IDLE until the next `load_i`.
- Build without `DOWN_TIMER_PRESCALER_EN`, psc 5, load 3 one-shot → expiry visible on cycle 5, same as psc 0.
